// File: rtl/dp_pkg.sv
// dp_pkg: opcodes, sequencer states and helpers shared by the datapath and its ALU.
// MUL/DIV opcodes are only legal in builds that define MULDIV_EN.
package dp_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
    OP_ROR, OP_ROL, OP_NEG, OP_NOT, OP_MUL, OP_DIV
  } op_e;
  typedef enum logic [2:0] {S_IDLE, S_TY, S_TALU, S_TWLO, S_TWHI, S_DONE} state_e;
  localparam logic [3:0] OP_LAST = 4'd12;
  function automatic int shamt_w(input int w);
    return $clog2(w);
  endfunction
  function automatic logic is_muldiv(input logic [3:0] o);
    return o == OP_MUL || o == OP_DIV;
  endfunction
endpackage

// File: rtl/dp_alu.sv
// dp_alu: combinational ALU, A=Y and B=bus, result split into zhigh:zlow.
// MUL/DIV logic exists only when MULDIV_EN is defined; otherwise those opcodes are illegal.
module dp_alu import dp_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] zhigh,
  output logic [WIDTH-1:0] zlow,
  output logic             illegal
);
  localparam int SW = shamt_w(WIDTH);
  localparam logic [SW:0] WL = (SW+1)'(WIDTH);
  logic [SW-1:0]    w_sh;
  logic [WIDTH-1:0] w_simple;
  assign w_sh = b[SW-1:0];
  always_comb begin
    w_simple = '0;
    case (op)
      OP_ADD:  w_simple = a + b;
      OP_SUB:  w_simple = a - b;
      OP_AND:  w_simple = a & b;
      OP_OR:   w_simple = a | b;
      OP_SHR:  w_simple = a >> w_sh;
      OP_SHRA: w_simple = $unsigned($signed(a) >>> w_sh);
      OP_SHL:  w_simple = a << w_sh;
      OP_ROR:  w_simple = (a >> w_sh) | (a << (WL - {1'b0, w_sh}));
      OP_ROL:  w_simple = (a << w_sh) | (a >> (WL - {1'b0, w_sh}));
      OP_NEG:  w_simple = -b;
      OP_NOT:  w_simple = ~b;
      default: w_simple = '0;
    endcase
  end
`ifdef MULDIV_EN
  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [WIDTH-1:0]   w_q;
  logic signed [WIDTH-1:0]   w_r;
  logic                      w_dz;
  logic                      w_ovf;
  assign w_prod = $signed(a) * $signed(b);
  assign w_dz   = b == '0;
  // MIN / -1 overflows the quotient, so it is resolved explicitly
  assign w_ovf  = a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1;
  assign w_q    = (w_dz || w_ovf) ? '0 : $signed(a) / $signed(b);
  assign w_r    = (w_dz || w_ovf) ? '0 : $signed(a) % $signed(b);
  always_comb begin
    zhigh   = '0;
    zlow    = w_simple;
    illegal = op > OP_LAST;
    if (op == OP_MUL) {zhigh, zlow} = w_prod;
    if (op == OP_DIV) begin
      zlow  = w_dz ? '1 : w_ovf ? a : w_q;
      zhigh = w_dz ? a : w_r;
    end
  end
`else
  assign zhigh   = '0;
  assign zlow    = w_simple;
  assign illegal = op > OP_LAST || is_muldiv(op);
`endif
endmodule

// File: rtl/param_datapath_seq.sv
// param_datapath_seq: register file + Y/Z/HI/LO on one bus, sequenced per start handshake.
// Define MULDIV_EN to enable MUL/DIV and the HI writeback state.
module param_datapath_seq import dp_pkg::*; #(
  parameter  int WIDTH = 32,
  parameter  int NREGS = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [AW-1:0]    rx,
  input  logic [AW-1:0]    ry,
  input  logic [AW-1:0]    rz,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] bus_dbg
);
  logic [WIDTH-1:0]   r_regs [NREGS];
  logic [WIDTH-1:0]   r_y;
  logic [2*WIDTH-1:0] r_z;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  state_e             r_state;
  logic [3:0]         r_op;
  logic [AW-1:0]      r_rx;
  logic [AW-1:0]      r_ry;
  logic [AW-1:0]      r_rz;
  logic               r_err;
  logic [WIDTH-1:0]   w_bus;
  logic [WIDTH-1:0]   w_zhigh;
  logic [WIDTH-1:0]   w_zlow;
  logic               w_illegal;
  always_comb begin
    w_bus = '0;
    case (r_state)
      S_TY:    w_bus = r_regs[r_rx];
      S_TALU:  w_bus = r_regs[r_ry];
      S_TWLO:  w_bus = r_z[WIDTH-1:0];
      S_TWHI:  w_bus = r_z[2*WIDTH-1:WIDTH];
      default: w_bus = '0;
    endcase
  end
  dp_alu #(.WIDTH(WIDTH)) u_alu (
    .a       (r_y),
    .b       (w_bus),
    .op      (r_op),
    .zhigh   (w_zhigh),
    .zlow    (w_zlow),
    .illegal (w_illegal)
  );
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_state <= S_IDLE;
      r_op    <= '0;
      r_rx    <= '0;
      r_ry    <= '0;
      r_rz    <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ld_en) r_regs[ld_addr] <= ld_data;
          if (start) begin
            r_op    <= op;
            r_rx    <= rx;
            r_ry    <= ry;
            r_rz    <= rz;
            r_err   <= 1'b0;
            r_state <= S_TY;
          end
        end
        S_TY: begin
          r_y     <= w_bus;
          r_state <= S_TALU;
        end
        S_TALU: begin
          if (w_illegal) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_z     <= {w_zhigh, w_zlow};
            r_state <= S_TWLO;
          end
        end
        S_TWLO: begin
`ifdef MULDIV_EN
          if (is_muldiv(r_op)) begin
            r_lo    <= w_bus;
            r_state <= S_TWHI;
          end else begin
            r_regs[r_rz] <= w_bus;
            r_state      <= S_DONE;
          end
`else
          r_regs[r_rz] <= w_bus;
          r_state      <= S_DONE;
`endif
        end
`ifdef MULDIV_EN
        S_TWHI: begin
          r_hi    <= w_bus;
          r_state <= S_DONE;
        end
`endif
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign busy    = r_state == S_TY || r_state == S_TALU || r_state == S_TWLO || r_state == S_TWHI;
  assign done    = r_state == S_DONE;
  assign err     = done && r_err;
  assign rd_data = r_regs[rd_addr];
  assign hi      = r_hi;
  assign lo      = r_lo;
  assign bus_dbg = w_bus;
endmodule

// File: tb/tb_param_datapath_seq.sv
// tb_param_datapath_seq: vector table plus corner sequences for param_datapath_seq.
// MUL/DIV expectations follow whether MULDIV_EN is defined.
module tb_param_datapath_seq;
  import dp_pkg::*;
  logic        clock = 0, clear = 0, start = 0, ld_en = 0;
  logic [3:0]  op = 0, rx = 0, ry = 0, rz = 0, ld_addr = 0, rd_addr = 0;
  logic [31:0] ld_data = 0;
  logic        busy, done, err;
  logic [31:0] rd_data, hi, lo, bus_dbg;
  int          errors = 0, checks = 0;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, r3, hi, lo;
    logic        e;
    int          lat;
    bit          md;
  } vec_t;
  vec_t        vecs[$];
  vec_t        exp_q[$];
  logic [31:0] m_hi = 0, m_lo = 0;
  always #5 clock = ~clock;
  param_datapath_seq dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .rx(rx), .ry(ry), .rz(rz),
    .busy(busy), .done(done), .err(err), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .hi(hi), .lo(lo), .bus_dbg(bus_dbg)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic ld(input logic [3:0] a, input logic [31:0] d);
    @(negedge clock);
    ld_en = 1; ld_addr = a; ld_data = d;
    @(posedge clock); #1;
    ld_en = 0;
  endtask
  // mode 0: plain; 1: host load on the start edge; 2: hold start and load R6 while busy
  task automatic run(input logic [3:0] o, input logic [3:0] x, input logic [3:0] y, input logic [3:0] z,
                     input int mode, output int lat, output int bc, output int dc, output logic es);
    @(negedge clock);
    op = o; rx = x; ry = y; rz = z; start = 1; ld_en = (mode == 1);
    @(posedge clock); #1;
    start = (mode == 2);
    ld_en = (mode == 2);
    if (mode == 2) begin ld_addr = 6; ld_data = 32'hAA; end
    lat = 0; bc = busy ? 1 : 0; dc = 0; es = 0;
    for (int i = 0; i < 8 && dc == 0; i++) begin
      @(posedge clock); #1;
      lat++;
      if (done) begin dc++; es = err; start = 0; ld_en = 0; end
      else if (busy) bc++;
    end
    start = 0; ld_en = 0;
    repeat (3) begin @(posedge clock); #1; if (done) dc++; end
  endtask
  task automatic add(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] r3,
                     input logic [31:0] h, input logic [31:0] l, input logic e, input int lat, input bit md);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.r3 = r3; v.hi = h; v.lo = l; v.e = e; v.lat = lat; v.md = md;
    vecs.push_back(v);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end
  initial begin
    int lat, bc, dc, dsum;
    logic es;
    vec_t v;
    localparam logic [31:0] SENT = 32'hDEAD0000;
    add(OP_ADD, 7, 5, 12, 0, 0, 0, 3, 0);
    add(OP_SUB, 5, 7, 32'hFFFFFFFE, 0, 0, 0, 3, 0);
    add(OP_AND, 32'hF0F0, 32'hFF00, 32'hF000, 0, 0, 0, 3, 0);
    add(OP_OR, 32'hF0F0, 32'h0F0F, 32'hFFFF, 0, 0, 0, 3, 0);
    add(OP_SHR, 32'h80000000, 4, 32'h08000000, 0, 0, 0, 3, 0);
    add(OP_SHRA, 32'h80000000, 4, 32'hF8000000, 0, 0, 0, 3, 0);
    add(OP_SHL, 1, 31, 32'h80000000, 0, 0, 0, 3, 0);
    add(OP_ROR, 32'h12345678, 4, 32'h81234567, 0, 0, 0, 3, 0);
    add(OP_ROL, 32'h12345678, 36, 32'h23456781, 0, 0, 0, 3, 0);
    add(OP_SHR, 32'hABCD, 32, 32'hABCD, 0, 0, 0, 3, 0);
    add(OP_NEG, 0, 5, 32'hFFFFFFFB, 0, 0, 0, 3, 0);
    add(OP_NOT, 0, 32'h0F0F0F0F, 32'hF0F0F0F0, 0, 0, 0, 3, 0);
`ifdef MULDIV_EN
    add(OP_MUL, 32'hFFFFFFFD, 7, SENT, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 4, 1);
    add(OP_DIV, 17, 32'hFFFFFFFB, SENT, 2, 32'hFFFFFFFD, 0, 4, 1);
    add(OP_DIV, 17, 0, SENT, 17, 32'hFFFFFFFF, 0, 4, 1);
    add(OP_DIV, 32'h80000000, 32'hFFFFFFFF, SENT, 0, 32'h80000000, 0, 4, 1);
    add(OP_DIV, 32'hFFFFFFF9, 2, SENT, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 4, 1);
`else
    add(OP_MUL, 32'hFFFFFFFD, 7, SENT, 0, 0, 1, 2, 0);
    add(OP_DIV, 17, 5, SENT, 0, 0, 1, 2, 0);
`endif
    add(4'd13, 1, 2, SENT, 0, 0, 1, 2, 0);
    add(4'd14, 1, 2, SENT, 0, 0, 1, 2, 0);
    add(4'd15, 1, 2, SENT, 0, 0, 1, 2, 0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_bus", bus_dbg, 0);
    rd_addr = 3; #1;
    chk("rst_r3", rd_data, 0);
    @(negedge clock); clear = 1;
    foreach (vecs[i]) begin
      ld(1, vecs[i].a); ld(2, vecs[i].b); ld(3, SENT);
      exp_q.push_back(vecs[i]);
      run(vecs[i].op, 1, 2, 3, 0, lat, bc, dc, es);
      v = exp_q.pop_front();
      if (v.md && !v.e) begin m_hi = v.hi; m_lo = v.lo; end
      rd_addr = 3; #1;
      chk($sformatf("v%0d_r3", i), rd_data, v.r3);
      chk($sformatf("v%0d_err", i), es, v.e);
      chk($sformatf("v%0d_lat", i), lat, v.lat);
      chk($sformatf("v%0d_busy", i), bc, v.lat);
      chk($sformatf("v%0d_done", i), dc, 1);
      chk($sformatf("v%0d_hi", i), hi, m_hi);
      chk($sformatf("v%0d_lo", i), lo, m_lo);
    end
    ld(4, 32'h80000000); ld(5, 4);
    run(OP_SHRA, 4, 5, 4, 0, lat, bc, dc, es);
    rd_addr = 4; #1;
    chk("dst_src_r4", rd_data, 32'hF8000000);
    chk("dst_src_done", dc, 1);
    ld(2, 5);
    ld_addr = 1; ld_data = 100;
    run(OP_ADD, 1, 2, 3, 1, lat, bc, dc, es);
    rd_addr = 3; #1;
    chk("ld_start_r3", rd_data, 105);
    rd_addr = 1; #1;
    chk("ld_start_r1", rd_data, 100);
    ld(6, 32'h66); ld(1, 7);
    run(OP_ADD, 1, 2, 3, 2, lat, bc, dc, es);
    rd_addr = 6; #1;
    chk("busy_ld_r6", rd_data, 32'h66);
    chk("busy_start_done", dc, 1);
    rd_addr = 3; #1;
    chk("busy_start_r3", rd_data, 12);
    ld(3, 32'h55);
    @(negedge clock);
    op = OP_ADD; rx = 1; ry = 2; rz = 3; start = 1;
    @(posedge clock); #1;
    start = 0;
    @(posedge clock); @(posedge clock); #1;
    chk("twlo_bus", bus_dbg, 12);
    clear = 0; #1;
    chk("clr_busy", busy, 0);
    chk("clr_done", done, 0);
    rd_addr = 3; #1;
    chk("clr_r3", rd_data, 0);
    rd_addr = 1; #1;
    chk("clr_r1", rd_data, 0);
    @(negedge clock); clear = 1;
    dsum = 0;
    repeat (6) begin @(posedge clock); #1; if (done) dsum++; end
    chk("clr_no_done", dsum, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/param_datapath_seq.md
Name: param_datapath_seq

Overview:
Parametrised successor of the CPU bus datapath. It contains a WIDTH-bit general register file (NREGS entries), plus HI/LO, Y and a 2·WIDTH Z register, all joined by a single internal bus. A built-in micro-sequencer executes one register-to-register ALU command per start handshake (Y-load, ALU-to-Z, Z-writeback T-states), so no external per-cycle control strobes are needed. A host load/readback port initialises and inspects registers while the datapath is idle.

Parameters:
WIDTH, 32, datapath word width (≥8, power of 2)
NREGS, 16, number of general registers (power of 2, ≥4); AW = clog2(NREGS) derived localparam

Ports:
clock  in  1  rising-edge clock
clear  in  1  asynchronous active-low reset
start  in  1  command request; sampled only in IDLE
op  in  4  opcode (see Behaviour)
rx  in  AW  operand-A register index (via Y)
ry  in  AW  operand-B register index (driven on bus during ALU step; shift count source)
rz  in  AW  destination register index
busy  out  1  high from first T-state through last write state
done  out  1  one-cycle completion pulse
err  out  1  valid with done; illegal opcode
ld_en  in  1  host register write; honoured only in IDLE
ld_addr  in  AW  host write index
ld_data  in  WIDTH  host write data
rd_addr  in  AW  host read index
rd_data  out  WIDTH  combinational R[rd_addr]
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
bus_dbg  out  WIDTH  current internal bus value (0 when undriven)

Behaviour:
- Reset (clear=0, async): all registers, Y, Z, HI, LO = 0; state IDLE; busy=done=err=0.
- Opcodes: 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 NEG(B), 10 NOT(B), 11 MUL, 12 DIV, 13–15 illegal. A=Y, B=bus.
- Shift/rotate count = B[clog2(WIDTH)-1:0]; count 0 leaves A unchanged.
- Non-MUL/DIV: Zlow = result mod 2^WIDTH, Zhigh = 0.
- MUL: signed A×B, 2·WIDTH product; Zhigh:Zlow = product.
- DIV: signed; Zlow = quotient truncated toward zero, Zhigh = remainder (sign of dividend). B=0 → Zlow=all ones, Zhigh=A. A=MIN, B=−1 → Zlow=MIN, Zhigh=0.
- FSM: IDLE → TY (bus=R[rx], Y←bus) → TALU (bus=R[ry], Z←ALU) → TWLO → [TWHI] → DONE → IDLE.
  - TWLO: bus=Zlow; R[rz]←bus for simple ops, LO←bus for MUL/DIV.
  - TWHI (MUL/DIV only): bus=Zhigh, HI←bus.
  - DONE: done=1, busy=0, one cycle; start ignored.
- Command fields are latched at the start-sampling edge; changes during busy are ignored.
- Latency: done high in the cycle after the 3rd edge following the start-sampling edge (4th for MUL/DIV).
- Illegal opcode is detected in TALU: no Z, register, HI or LO write; go directly to DONE with err=1.
- rz equal to rx or ry is legal (Y captures A first; B is read before writeback).
- ld_en during busy or DONE is dropped. When ld_en and start are both high in IDLE: the load completes on that edge and the command starts; TY reads the post-load value on the next cycle.
- rd_data, hi and lo reflect register contents continuously; a host read of a register being written shows the old value until the write edge.
- Reset mid-command: state and all storage cleared immediately; no done pulse.

Optional Feature:
MULDIV_EN: when defined, MUL/DIV hardware and the TWHI state are present. When undefined, opcodes 11 and 12 are illegal (err=1, no writes); HI and LO are only cleared by reset and are otherwise held.

Decomposition:
- Package dp_pkg: opcode enum (op_e), FSM state enum (state_e), opcode constants, and a function for shift-count width.
- One sub-module, dp_alu: combinational, WIDTH-parametrised, inputs A, B, op; outputs zhigh, zlow, illegal.
- Sequencer, bus mux and register file stay in the top module.

Test Plan:
- R1=7, R2=5 loaded; ADD rx=1 ry=2 rz=3 → done 3 cycles after start edge, R3=12, err=0, busy high exactly 3 cycles.
- R4=0x80000000, R5=4; SHRA rx=4 ry=5 rz=4 (dest=src) → R4=0xF8000000; ROL with R5=36 → rotate by 4.
- MUL R1=−3, R2=7 → LO=0xFFFFFFEB, HI=0xFFFFFFFF, done at 4 cycles; DIV 17/−5 → LO=−3, HI=2; DIV by 0 → LO=0xFFFFFFFF, HI=17.
- op=14 → done with err=1 after 2 cycles, R/HI/LO unchanged; without MULDIV_EN, op=11 → err=1.
- ld_en in busy with ld_addr=6, ld_data=0xAA → R6 unchanged; start while busy → ignored, single done pulse.
- clear asserted during TWLO of ADD into R3 → R3=0, busy=done=0 immediately, no done pulse after release.
